sigmoid_alu: RTL and testbench

Arithmetic datapath between `networkController` and the sigmoid register file. Each cycle it multiplies the four registered weight/input operand pairs and sums them in a two-stage pipeline. On `accumulate` it adds that sum into a saturating accumulator. It also continuously drives a registered 4-bit hard-sigmoid of (accumulator + scaled bias) on `ALUOutput`, which the controller writes back on `sigmoid_write_en`.

---
 rtl/nn_pkg.sv | 19 +
 rtl/hard_sigmoid.sv | 37 +++
 rtl/sigmoid_alu.sv | 119 +++++++++++
 tb/tb_sigmoid_alu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared widths and default tuning constants for the neural-network datapath.
package nn_pkg;

  localparam int WEIGHT_W  = 4;
  localparam int INPUT_W   = 4;
  localparam int BIAS_W    = 4;
  localparam int OUT_W     = 4;
  localparam int NUM_PAIRS = 4;

  // Product range -120..105 fits 9 bits; four of them (-480..420) fit 11 bits.
  localparam int PROD_W = 9;
  localparam int SUM_W  = 11;

  localparam int DEF_ACC_W      = 16;
  localparam int DEF_BIAS_SHIFT = 4;
  localparam int DEF_SIG_SHIFT  = 5;
  localparam int SIG_OFFSET     = 8;

endpackage

// File: rtl/hard_sigmoid.sv
// Combinational hard-sigmoid: clamp(((acc + (bias <<< BIAS_SHIFT)) >>> SIG_SHIFT) + 8, 0, 15).
module hard_sigmoid
  import nn_pkg::*;
#(
  parameter int ACC_W      = DEF_ACC_W,
  parameter int BIAS_SHIFT = DEF_BIAS_SHIFT,
  parameter int SIG_SHIFT  = DEF_SIG_SHIFT
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [BIAS_W-1:0] bias_i,
  output logic [OUT_W-1:0]  sig_o
);

  localparam logic signed [ACC_W:0] OFFSET_EXT  = (ACC_W+1)'(SIG_OFFSET);
  localparam logic signed [ACC_W:0] OUT_MAX_EXT = (ACC_W+1)'((2**OUT_W) - 1);

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] bias_ext;
  logic signed [ACC_W:0] x_val;
  logic signed [ACC_W:0] y_val;

  // One extra bit of headroom so acc + scaled bias cannot wrap.
  always_comb begin
    acc_ext  = {acc_i[ACC_W-1], acc_i};
    bias_ext = {{(ACC_W+1-BIAS_W){bias_i[BIAS_W-1]}}, bias_i};
    x_val    = acc_ext + (bias_ext <<< BIAS_SHIFT);
    y_val    = (x_val >>> SIG_SHIFT) + OFFSET_EXT;
    if (y_val[ACC_W]) begin
      sig_o = '0;
    end else if (y_val > OUT_MAX_EXT) begin
      sig_o = '1;
    end else begin
      sig_o = y_val[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/sigmoid_alu.sv
// Four-pair multiply, two-stage adder pipeline, saturating accumulator and registered hard-sigmoid output.
module sigmoid_alu
  import nn_pkg::*;
#(
  parameter int ACC_W      = DEF_ACC_W,
  parameter int BIAS_SHIFT = DEF_BIAS_SHIFT,
  parameter int SIG_SHIFT  = DEF_SIG_SHIFT
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [WEIGHT_W-1:0] weight1,
  input  logic [WEIGHT_W-1:0] weight2,
  input  logic [WEIGHT_W-1:0] weight3,
  input  logic [WEIGHT_W-1:0] weight4,
  input  logic [INPUT_W-1:0]  input1,
  input  logic [INPUT_W-1:0]  input2,
  input  logic [INPUT_W-1:0]  input3,
  input  logic [INPUT_W-1:0]  input4,
  input  logic [BIAS_W-1:0]   bias,
  input  logic                clear,
  input  logic                accumulate,
  output logic [OUT_W-1:0]    ALUOutput,
  output logic                acc_overflow
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [WEIGHT_W-1:0] w_arr [NUM_PAIRS];
  logic [INPUT_W-1:0]  in_arr[NUM_PAIRS];

  assign w_arr[0]  = weight1;
  assign w_arr[1]  = weight2;
  assign w_arr[2]  = weight3;
  assign w_arr[3]  = weight4;
  assign in_arr[0] = input1;
  assign in_arr[1] = input2;
  assign in_arr[2] = input3;
  assign in_arr[3] = input4;

  logic signed [PROD_W-1:0] prod_d[NUM_PAIRS];
  logic signed [PROD_W-1:0] prod_q[NUM_PAIRS];
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W:0]    acc_sum;
  logic                     ovf_d;
  logic                     ovf_q;
  logic [OUT_W-1:0]         sig_d;
  logic [OUT_W-1:0]         alu_out_q;

  // Product of the low 9 bits is exact because every true product fits 9-bit signed.
  generate
    for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_mul
      assign prod_d[gi] = {{(PROD_W-WEIGHT_W){w_arr[gi][WEIGHT_W-1]}}, w_arr[gi]}
                        * {{(PROD_W-INPUT_W){1'b0}}, in_arr[gi]};
    end
  endgenerate

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      sum_d = sum_d + {{(SUM_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
    end
  end

  always_comb begin
    acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-SUM_W){sum_q[SUM_W-1]}}, sum_q};
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (accumulate) begin
      // Top two bits disagree exactly when the wide sum left the ACC_W range.
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
        acc_d = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        ovf_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
    end
  end

  hard_sigmoid #(
    .ACC_W      (ACC_W),
    .BIAS_SHIFT (BIAS_SHIFT),
    .SIG_SHIFT  (SIG_SHIFT)
  ) u_hard_sigmoid (
    .acc_i  (acc_q),
    .bias_i (bias),
    .sig_o  (sig_d)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NUM_PAIRS; k++) begin
        prod_q[k] <= '0;
      end
      sum_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      alu_out_q <= '0;
    end else begin
      for (int k = 0; k < NUM_PAIRS; k++) begin
        prod_q[k] <= prod_d[k];
      end
      sum_q     <= sum_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      alu_out_q <= sig_d;
    end
  end

  assign ALUOutput    = alu_out_q;
  assign acc_overflow = ovf_q;

endmodule

// File: tb/tb_sigmoid_alu.sv
// Self-checking bench for sigmoid_alu: table vectors, hand-written corner sequences and a randomized run.
module tb_sigmoid_alu;

  localparam int ACC_W      = 16;
  localparam int BIAS_SHIFT = 4;
  localparam int SIG_SHIFT  = 5;
  localparam int ACC_MAXI   = (2**(ACC_W-1)) - 1;
  localparam int ACC_MINI   = -(2**(ACC_W-1));

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       clear = 1'b0;
  logic       accumulate = 1'b0;
  logic [3:0] ALUOutput;
  logic       acc_overflow;

  int wv[4];
  int iv[4];
  int bv;

  int checks = 0;
  int errors = 0;

  int m_acc;
  int m_ovf;
  int mq[$];

  always #5 clk = ~clk;

  sigmoid_alu #(
    .ACC_W      (ACC_W),
    .BIAS_SHIFT (BIAS_SHIFT),
    .SIG_SHIFT  (SIG_SHIFT)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .weight1      (4'(wv[0])),
    .weight2      (4'(wv[1])),
    .weight3      (4'(wv[2])),
    .weight4      (4'(wv[3])),
    .input1       (4'(iv[0])),
    .input2       (4'(iv[1])),
    .input3       (4'(iv[2])),
    .input4       (4'(iv[3])),
    .bias         (4'(bv)),
    .clear        (clear),
    .accumulate   (accumulate),
    .ALUOutput    (ALUOutput),
    .acc_overflow (acc_overflow)
  );

  typedef struct {
    string name;
    int    w[4];
    int    i[4];
    int    b;
    int    n;
    int    e_acc;
    int    e_out;
    int    e_ovf;
  } vec_t;

  function automatic vec_t mk(string name, int w0, int w1, int w2, int w3,
                              int i0, int i1, int i2, int i3,
                              int b, int n, int e_acc, int e_out, int e_ovf);
    vec_t v;
    v.name = name;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.i[0] = i0; v.i[1] = i1; v.i[2] = i2; v.i[3] = i3;
    v.b = b; v.n = n; v.e_acc = e_acc; v.e_out = e_out; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Floor-divide based hard sigmoid, straight from the arithmetic definition.
  function automatic int hs(int acc, int b);
    int x, d, y;
    d = 1 << SIG_SHIFT;
    x = acc + b * (1 << BIAS_SHIFT);
    if (x >= 0) y = x / d;
    else        y = -((-x + d - 1) / d);
    y = y + 8;
    if (y < 0)  y = 0;
    if (y > 15) y = 15;
    return y;
  endfunction

  task automatic model_reset();
    mq.delete();
    mq.push_back(0);
    mq.push_back(0);
    m_acc = 0;
    m_ovf = 0;
  endtask

  // One clock: the model consumes the dot product of operands applied two edges earlier.
  task automatic step();
    int s, used, nxt, eo;
    s = 0;
    for (int k = 0; k < 4; k++) s += wv[k] * iv[k];
    used = mq.pop_front();
    mq.push_back(s);
    eo = hs(m_acc, bv);
    if (clear) begin
      m_acc = 0;
      m_ovf = 0;
    end else if (accumulate) begin
      nxt = m_acc + used;
      if (nxt > ACC_MAXI) begin nxt = ACC_MAXI; m_ovf = 1; end
      if (nxt < ACC_MINI) begin nxt = ACC_MINI; m_ovf = 1; end
      m_acc = nxt;
    end
    @(posedge clk);
    #1;
    chk("model_out", int'(ALUOutput), eo);
    chk("model_ovf", int'(acc_overflow), m_ovf);
    chk("model_acc", int'($signed(dut.acc_q)), m_acc);
  endtask

  task automatic set_ops(int w, int i);
    for (int k = 0; k < 4; k++) begin
      wv[k] = w;
      iv[k] = i;
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = mk("pos60",  1, 1, 1, 1, 15, 15, 15, 15, 0, 1,     60,  9, 0);
    vecs[1] = mk("neg480", -8, -8, -8, -8, 15, 15, 15, 15, 0, 1, -480, 0, 0);
    vecs[2] = mk("bias7",  0, 0, 0, 0, 0, 0, 0, 0, 7, 0,            0, 11, 0);
    vecs[3] = mk("mixed",  3, -2, 5, -1, 4, 7, 9, 15, 2, 2,        56, 10, 0);
    vecs[4] = mk("possat", 7, 7, 7, 7, 15, 15, 15, 15, 0, 79,   32767, 15, 1);
    vecs[5] = mk("negsat", -8, -8, -8, -8, 15, 15, 15, 15, 0, 70, -32768, 0, 1);

    set_ops(0, 0);
    bv = 0;
    model_reset();
    #1 n_rst = 1'b0;
    #11;
    chk("reset_out", int'(ALUOutput), 0);
    chk("reset_ovf", int'(acc_overflow), 0);
    chk("reset_acc", int'($signed(dut.acc_q)), 0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    step();
    chk("first_edge_out", int'(ALUOutput), 8);
    $display("reset: out=%0d ovf=%0d", ALUOutput, acc_overflow);

    foreach (vecs[v]) begin
      for (int k = 0; k < 4; k++) begin
        wv[k] = vecs[v].w[k];
        iv[k] = vecs[v].i[k];
      end
      bv = vecs[v].b;
      clear = 1'b1;
      step();
      clear = 1'b0;
      step();
      accumulate = 1'b1;
      repeat (vecs[v].n) step();
      accumulate = 1'b0;
      step();
      chk({vecs[v].name, "_acc"}, int'($signed(dut.acc_q)), vecs[v].e_acc);
      chk({vecs[v].name, "_out"}, int'(ALUOutput), vecs[v].e_out);
      chk({vecs[v].name, "_ovf"}, int'(acc_overflow), vecs[v].e_ovf);
      $display("vec %s: acc=%0d out=%0d ovf=%0d", vecs[v].name,
               $signed(dut.acc_q), ALUOutput, acc_overflow);
    end

    // Clear drops the sticky flag left by the saturation vector.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_acc", int'($signed(dut.acc_q)), 0);
    chk("clear_ovf", int'(acc_overflow), 0);
    $display("clear after saturation: acc=%0d ovf=%0d", $signed(dut.acc_q), acc_overflow);

    // Bias step response with acc at zero.
    set_ops(0, 0);
    bv = 7;
    step();
    chk("bias_pos_out", int'(ALUOutput), 11);
    bv = -8;
    step();
    chk("bias_neg_out", int'(ALUOutput), 4);
    $display("bias seq: out=%0d", ALUOutput);
    bv = 0;

    // Clear wins over accumulate in the same cycle.
    set_ops(1, 15);
    step();
    step();
    accumulate = 1'b1;
    step();
    chk("pre_clr_acc", int'($signed(dut.acc_q)), 60);
    clear = 1'b1;
    step();
    clear = 1'b0;
    accumulate = 1'b0;
    chk("clr_acc_same_cycle", int'($signed(dut.acc_q)), 0);
    $display("clear+accumulate: acc=%0d", $signed(dut.acc_q));

    // Reset mid-accumulation takes effect without a clock edge.
    set_ops(7, 15);
    accumulate = 1'b1;
    repeat (4) step();
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_acc", int'($signed(dut.acc_q)), 0);
    chk("async_rst_sum", int'($signed(dut.sum_q)), 0);
    chk("async_rst_prod", int'($signed(dut.prod_q[0])), 0);
    chk("async_rst_out", int'(ALUOutput), 0);
    chk("async_rst_ovf", int'(acc_overflow), 0);
    accumulate = 1'b0;
    model_reset();
    @(posedge clk);
    #1 n_rst = 1'b1;
    set_ops(0, 0);
    step();
    chk("post_rst_out", int'(ALUOutput), 8);
    $display("async reset: out=%0d", ALUOutput);

    for (int r = 0; r < 300; r++) begin
      for (int k = 0; k < 4; k++) begin
        wv[k] = int'($urandom_range(15)) - 8;
        iv[k] = int'($urandom_range(15));
      end
      bv = int'($urandom_range(15)) - 8;
      accumulate = ($urandom_range(99) < 40);
      clear = ($urandom_range(99) < 5);
      step();
      $display("rand %0d: acc=%0d out=%0d ovf=%0d", r, $signed(dut.acc_q), ALUOutput, acc_overflow);
    end
    clear = 1'b0;
    accumulate = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
